kf_host_ctrl: RTL and testbench
===============================

# kf_host_ctrl

Host-side initiator for the Kalman-filter core's external port. It accepts a stream of measurement words over a valid/ready handshake and writes each frame of NIN words into the core's data bank through DIR/WRITE while the core is idle. It then pulses START, captures the first result strobe of the run and presents it on a one-entry valid/ready output. It sits between the system bus adapter and the KF core top.

## Interface
- W, 24, data width (matches core datapath)
- ADDRW, 5, core register address width
- NIN, 2, words written per frame (1..2^ADDRW)
- BASE_ADDR, 0, core address of first frame word; word i goes to BASE_ADDR+i, truncated to ADDRW bits
- TIMEOUT, 1024, max cycles spent in any wait state; counter width is clog2(TIMEOUT+1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input word valid
- s_ready  out  1  input word accepted
- s_data  in  W  input word
- m_valid  out  1  result valid
- m_ready  in  1  result consumed
- m_data  out  W  result
- kf_start  out  1  to core START
- kf_data_in  out  W  to core DATA_IN
- kf_dir  out  ADDRW  to core DIR
- kf_write  out  1  to core WRITE
- kf_ready  in  1  from core READY
- kf_data_out  in  W  from core DATA_OUT
- kf_data_out_valid  in  1  from core data_out_valid
- busy  out  1  high whenever state is not LOAD
- timeout_err  out  1  sticky; cleared only by reset

## Operation
- States: LOAD, ARM, WAIT_BUSY, WAIT_RES, WAIT_DONE. Reset state is LOAD.
- LOAD:
  - s_ready = kf_ready; this is combinational and is the only combinational output.
  - On each s_valid && s_ready, register kf_data_in=s_data, kf_dir=BASE_ADDR+idx, kf_write=1, then increment idx.
  - On the NIN-th accept, idx returns to 0 and the state goes to ARM.
- ARM: when m_valid==0, assert kf_start for one cycle and go to WAIT_BUSY. Otherwise hold; a frame never starts while a result is unconsumed.
- WAIT_BUSY: when kf_ready==0, go to WAIT_RES.
- WAIT_RES: on kf_data_out_valid, latch m_data=kf_data_out, set m_valid=1 and go to WAIT_DONE.
- WAIT_DONE: when kf_ready==1, go to LOAD.
- Result capture:
  - The first kf_data_out_valid seen in WAIT_BUSY or WAIT_RES is captured, and the state goes directly to WAIT_DONE.
  - Later strobes in the same frame are ignored.
- Output handshake: m_valid clears on m_valid && m_ready. m_data holds its value until the next capture.
- Timeout:
  - The wait counter resets on entry to each of WAIT_BUSY, WAIT_RES and WAIT_DONE, and increments every cycle while in them.
  - When it reaches TIMEOUT: set timeout_err, set m_valid=0, clear idx and go to LOAD.
- kf_ready dropping in LOAD mid-frame: stall, with s_ready=0. idx is preserved and the frame resumes when kf_ready returns.

## Timing
- Reset values: s_ready follows kf_ready; m_valid=0, m_data=0, kf_start=0, kf_write=0, kf_dir=0, kf_data_in=0, busy=0, timeout_err=0, idx=0.
- Write latency:
  - A handshake at edge k drives kf_write high for exactly the cycle after edge k, with kf_dir and kf_data_in stable in that cycle.
  - kf_dir and kf_data_in hold their values afterward.
  - Back-to-back accepts give one write per cycle.
- START latency:
  - The NIN-th handshake at edge k drives kf_start high in cycle k+2 (one cycle in ARM) when m_valid==0.
  - The pulse is exactly one cycle wide.
- kf_start and kf_write are never high in the same cycle.
- Capture: a kf_data_out_valid sampled at edge j gives m_valid=1 from cycle j+1.
- Simultaneous m_ready handshake and capture: capture wins and m_valid stays 1. This can only occur across frames, because ARM blocks while m_valid is set.
- Reset asserted mid-operation clears all state immediately, including an in-flight kf_write or kf_start.

## Test plan
- Basic frame, NIN=2, BASE_ADDR=4, kf_ready=1:
  - Stimulus: send 0x000100 then 0x000200 on consecutive cycles.
  - Required: writes 0x000100 to dir 4 and 0x000200 to dir 5 on consecutive cycles, then kf_start pulses once, one cycle after the second write.
- Result path:
  - Stimulus: model core drops kf_ready 1 cycle after start, strobes kf_data_out_valid with 0x00ABCD after 30 cycles, raises kf_ready 5 cycles later; m_ready=1.
  - Required: m_data=0x00ABCD with m_valid for 1 cycle; busy falls when kf_ready rises.
- Backpressure:
  - Stimulus: hold m_ready=0 after first result, then send a second frame.
  - Required: both writes occur but kf_start is withheld until m_ready pulses; m_data stays at the first result until then.
- Core busy during load:
  - Stimulus: drop kf_ready after the first word.
  - Required: s_ready=0 and no kf_write; the second word goes to dir BASE_ADDR+1 after kf_ready returns.
- Timeout, TIMEOUT=16:
  - Stimulus: core never drops kf_ready after start.
  - Required: timeout_err=1 exactly 16 cycles after entering WAIT_BUSY, return to LOAD, and the next frame writes start at BASE_ADDR.
- Async reset mid-WAIT_RES:
  - Required: all outputs return to reset values without a clock edge; a following frame operates normally.

Source files
------------

// File: rtl/kf_host_ctrl.sv
// kf_host_ctrl
// Host-side initiator for the Kalman-filter core's external port.
// It collects NIN measurement words from a valid/ready stream and writes
// them into the core's data bank through DIR/WRITE. The core must be idle
// while this happens. It then pulses START and waits for the core to go
// busy and then idle again. The first result strobe of the run is captured
// into a one-entry valid/ready output buffer.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   s_valid/s_ready      input word handshake; s_data carries the word
//   m_valid/m_ready      result handshake; m_data carries the result
//   kf_start             one-cycle START pulse to the core
//   kf_data_in/kf_dir    registered write data and address to the core
//   kf_write             registered write strobe to the core
//   kf_ready             core idle indication
//   kf_data_out(_valid)  core result word and its strobe
//   busy                 high whenever the controller is not loading
//   timeout_err          sticky wait-state timeout flag, cleared by reset
module kf_host_ctrl #(
    parameter int W         = 24,
    parameter int ADDRW     = 5,
    parameter int NIN       = 2,
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W-1:0]     m_data,
    output logic             kf_start,
    output logic [W-1:0]     kf_data_in,
    output logic [ADDRW-1:0] kf_dir,
    output logic             kf_write,
    input  logic             kf_ready,
    input  logic [W-1:0]     kf_data_out,
    input  logic             kf_data_out_valid,
    output logic             busy,
    output logic             timeout_err
);

    localparam int IDXW = (NIN > 1) ? $clog2(NIN) : 1;
    localparam int CW   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        LOAD,
        ARM,
        WAIT_BUSY,
        WAIT_RES,
        WAIT_DONE
    } state_t;

    state_t           state, state_n;
    logic [IDXW-1:0]  idx, idx_n;
    logic [CW-1:0]    wait_cnt, wait_cnt_n;
    logic             m_valid_n, kf_start_n, kf_write_n, timeout_err_n;
    logic [W-1:0]     m_data_n, kf_data_in_n;
    logic [ADDRW-1:0] kf_dir_n;

    logic accept;
    logic timed_out;

    // The input is accepted only while loading and while the core is idle.
    // If kf_ready drops mid-frame, loading stalls and idx keeps its value.
    assign s_ready   = (state == LOAD) && kf_ready;
    assign accept    = s_valid && s_ready;
    assign busy      = (state != LOAD);
    // This fires on the TIMEOUT-th consecutive cycle spent in the current wait state.
    assign timed_out = (wait_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        // NOTE: every signal gets a default before the case statement. No path can then leave a signal unassigned, so no latch is inferred.
        state_n       = state;
        idx_n         = idx;
        wait_cnt_n    = wait_cnt;
        kf_start_n    = 1'b0;
        kf_write_n    = 1'b0;
        kf_dir_n      = kf_dir;
        kf_data_in_n  = kf_data_in;
        m_data_n      = m_data;
        m_valid_n     = m_valid && !m_ready;
        timeout_err_n = timeout_err;

        unique case (state)
            LOAD: begin
                if (accept) begin
                    kf_write_n   = 1'b1;
                    kf_dir_n     = ADDRW'(BASE_ADDR + 32'(idx));
                    kf_data_in_n = s_data;
                    if (idx == IDXW'(NIN - 1)) begin
                        idx_n   = '0;
                        state_n = ARM;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end

            ARM: begin
                // A new run starts only after the previous result has been taken.
                if (!m_valid) begin
                    kf_start_n = 1'b1;
                    wait_cnt_n = '0;
                    state_n    = WAIT_BUSY;
                end
            end

            WAIT_BUSY, WAIT_RES: begin
                // The strobe has priority. It can arrive before the core is seen busy.
                if (kf_data_out_valid) begin
                    m_data_n   = kf_data_out;
                    m_valid_n  = 1'b1;
                    wait_cnt_n = '0;
                    state_n    = WAIT_DONE;
                end else if (state == WAIT_BUSY && !kf_ready) begin
                    wait_cnt_n = '0;
                    state_n    = WAIT_RES;
                end else if (timed_out) begin
                    timeout_err_n = 1'b1;
                    m_valid_n     = 1'b0;
                    idx_n         = '0;
                    state_n       = LOAD;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
            end

            WAIT_DONE: begin
                // Further strobes in this run are ignored here.
                if (kf_ready) begin
                    state_n = LOAD;
                end else if (timed_out) begin
                    timeout_err_n = 1'b1;
                    m_valid_n     = 1'b0;
                    idx_n         = '0;
                    state_n       = LOAD;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
            end

            default: state_n = LOAD;
        endcase
    end

    // Every register is reset, including the datapath registers, because the core
    // port must come out of reset at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD;
            idx         <= '0;
            wait_cnt    <= '0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            kf_start    <= 1'b0;
            kf_write    <= 1'b0;
            kf_dir      <= '0;
            kf_data_in  <= '0;
            timeout_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let all registers update together from the values of the previous cycle.
            state       <= state_n;
            idx         <= idx_n;
            wait_cnt    <= wait_cnt_n;
            m_valid     <= m_valid_n;
            m_data      <= m_data_n;
            kf_start    <= kf_start_n;
            kf_write    <= kf_write_n;
            kf_dir      <= kf_dir_n;
            kf_data_in  <= kf_data_in_n;
            timeout_err <= timeout_err_n;
        end
    end

endmodule

// File: tb/tb_kf_host_ctrl.sv
// tb_kf_host_ctrl
// Directed and randomized bench for kf_host_ctrl with NIN=2, BASE_ADDR=4
// and TIMEOUT=16. The core side is driven directly from the stimulus
// sequence. Expected write addresses, start decisions and results come from
// a small model. The model tracks the pending result, its value and the
// error flag.
module tb_kf_host_ctrl;

    localparam int W     = 24;
    localparam int ADDRW = 5;
    localparam int NIN   = 2;
    localparam int BASE  = 4;
    localparam int TO    = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [W-1:0]     s_data;
    logic             m_valid;
    logic             m_ready;
    logic [W-1:0]     m_data;
    logic             kf_start;
    logic [W-1:0]     kf_data_in;
    logic [ADDRW-1:0] kf_dir;
    logic             kf_write;
    logic             kf_ready;
    logic [W-1:0]     kf_data_out;
    logic             kf_data_out_valid;
    logic             busy;
    logic             timeout_err;

    always #5 clk = ~clk;

    kf_host_ctrl #(
        .W(W), .ADDRW(ADDRW), .NIN(NIN), .BASE_ADDR(BASE), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .kf_start(kf_start), .kf_data_in(kf_data_in), .kf_dir(kf_dir),
        .kf_write(kf_write), .kf_ready(kf_ready), .kf_data_out(kf_data_out),
        .kf_data_out_valid(kf_data_out_valid),
        .busy(busy), .timeout_err(timeout_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] fw [NIN];
    logic [W-1:0] exp_mdata;
    bit           exp_mvalid;
    bit           exp_err;
    bit           started;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Frame word i lands at BASE+i, wrapped into the address space
    function automatic logic [31:0] dir_of(input int i);
        return 32'((BASE + i) % (1 << ADDRW));
    endfunction

    task automatic randomize_frame();
        for (int i = 0; i < NIN; i++) fw[i] = W'($urandom);
    endtask

    task automatic check_reset_values();
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_kf_start", kf_start, 0);
        check("rst_kf_write", kf_write, 0);
        check("rst_kf_dir", kf_dir, 0);
        check("rst_kf_data_in", kf_data_in, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_s_ready", s_ready, kf_ready);
    endtask

    // Sends fw[] back-to-back with kf_ready=1. Returns at the sample point of
    // the cycle where START is due, which is two edges after the last accept.
    task automatic load_frame(output bit st);
        for (int i = 0; i < NIN; i++) begin
            s_valid = 1'b1;
            s_data  = fw[i];
            check("s_ready_load", s_ready, 1);
            tick();
            check("wr_en", kf_write, 1);
            check("wr_dir", kf_dir, dir_of(i));
            check("wr_data", kf_data_in, fw[i]);
            check("no_start_during_write", kf_start, 0);
        end
        s_valid = 1'b0;
        s_data  = '0;
        tick();
        check("wr_single", kf_write, 0);
        check("wr_dir_hold", kf_dir, dir_of(NIN - 1));
        check("start", kf_start, !exp_mvalid);
        check("m_valid_model", m_valid, exp_mvalid);
        check("m_data_model", m_data, exp_mdata);
        check("busy_after_load", busy, 1);
        st = !exp_mvalid;
    endtask

    // Core behaviour after START. The core goes busy immediately and strobes
    // the result after sdly cycles. A second strobe follows and must be
    // ignored. The core returns to idle after rdly more cycles.
    task automatic run_core(input int sdly, input logic [W-1:0] res, input int rdly, input bit mr);
        kf_ready = 1'b0;
        m_ready  = mr;
        tick();
        check("start_pulse_width", kf_start, 0);
        check("busy_in_run", busy, 1);
        repeat (sdly) tick();
        check("no_early_result", m_valid, 0);
        kf_data_out_valid = 1'b1;
        kf_data_out       = res;
        tick();
        kf_data_out_valid = 1'b0;
        kf_data_out       = '0;
        exp_mdata  = res;
        exp_mvalid = 1'b1;
        check("capture_valid", m_valid, 1);
        check("capture_data", m_data, res);
        if (mr) begin
            tick();
            exp_mvalid = 1'b0;
            check("m_valid_one_cycle", m_valid, 0);
        end
        kf_data_out_valid = 1'b1;
        kf_data_out       = ~res;
        tick();
        kf_data_out_valid = 1'b0;
        kf_data_out       = '0;
        check("late_strobe_data", m_data, exp_mdata);
        check("late_strobe_valid", m_valid, exp_mvalid);
        repeat (rdly) tick();
        check("busy_before_idle", busy, 1);
        kf_ready = 1'b1;
        tick();
        check("busy_falls", busy, 0);
        check("s_ready_idle", s_ready, 1);
        check("err_model", timeout_err, exp_err);
    endtask

    initial begin
        rst_n = 1'b0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        kf_ready = 1'b1; kf_data_out = '0; kf_data_out_valid = 1'b0;
        exp_mdata = '0; exp_mvalid = 1'b0; exp_err = 1'b0;

        // Reset values, with s_ready following kf_ready
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        kf_ready = 1'b0;
        #1;
        check("rst_s_ready_low", s_ready, 0);
        kf_ready = 1'b1;
        #1;
        rst_n = 1'b1;
        tick();
        check("idle_s_ready", s_ready, 1);

        // Basic frame, then the result path with m_ready=1. The strobe delay is
        // kept below TIMEOUT.
        fw[0] = 24'h000100;
        fw[1] = 24'h000200;
        load_frame(started);
        run_core(10, 24'h00ABCD, 5, 1'b1);

        // Backpressure: the result is held, and the next START waits for m_ready
        randomize_frame();
        load_frame(started);
        run_core($urandom_range(2, 12), W'($urandom), $urandom_range(1, 5), 1'b0);
        randomize_frame();
        load_frame(started);
        repeat (4) begin
            tick();
            check("start_withheld", kf_start, 0);
            check("held_m_valid", m_valid, 1);
            check("held_m_data", m_data, exp_mdata);
        end
        m_ready = 1'b1;
        tick();
        exp_mvalid = 1'b0;
        m_ready = 1'b0;
        check("m_valid_cleared", m_valid, 0);
        check("start_after_consume_not_yet", kf_start, 0);
        tick();
        check("start_after_consume", kf_start, 1);
        run_core($urandom_range(2, 12), W'($urandom), $urandom_range(1, 5), 1'b1);

        // Core goes busy during loading: the load stalls and resumes at the next address
        randomize_frame();
        s_valid = 1'b1;
        s_data  = fw[0];
        tick();
        check("stall_first_write", kf_write, 1);
        check("stall_first_dir", kf_dir, dir_of(0));
        kf_ready = 1'b0;
        s_data   = fw[1];
        #1;
        check("stall_s_ready", s_ready, 0);
        repeat (3) begin
            tick();
            check("stall_no_write", kf_write, 0);
            check("stall_dir_hold", kf_dir, dir_of(0));
        end
        kf_ready = 1'b1;
        #1;
        check("resume_s_ready", s_ready, 1);
        tick();
        check("resume_write", kf_write, 1);
        check("resume_dir", kf_dir, dir_of(1));
        check("resume_data", kf_data_in, fw[1]);
        s_valid = 1'b0;
        tick();
        check("resume_start", kf_start, 1);
        run_core($urandom_range(2, 12), W'($urandom), $urandom_range(1, 5), 1'b1);

        // Timeout: the core never goes busy after START
        randomize_frame();
        load_frame(started);
        for (int c = 1; c <= TO; c++) begin
            tick();
            if (c == TO - 1) begin
                check("no_timeout_early", timeout_err, 0);
                check("busy_before_timeout", busy, 1);
            end
        end
        exp_err = 1'b1;
        check("timeout_err", timeout_err, 1);
        check("timeout_to_load", busy, 0);
        check("timeout_m_valid", m_valid, 0);
        randomize_frame();
        load_frame(started);
        run_core($urandom_range(2, 12), W'($urandom), $urandom_range(1, 5), 1'b1);
        check("timeout_err_sticky", timeout_err, 1);

        // Asynchronous reset while waiting for the result
        randomize_frame();
        load_frame(started);
        kf_ready = 1'b0;
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        exp_err = 1'b0; exp_mvalid = 1'b0; exp_mdata = '0;
        check_reset_values();
        kf_ready = 1'b1;
        rst_n = 1'b1;
        tick();

        // Asynchronous reset during an in-flight write; idx must restart at 0
        randomize_frame();
        s_valid = 1'b1;
        s_data  = fw[0];
        tick();
        check("inflight_write", kf_write, 1);
        s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_kills_write", kf_write, 0);
        check("reset_clears_dir", kf_dir, 0);
        check("reset_clears_data", kf_data_in, 0);
        rst_n = 1'b1;
        tick();
        randomize_frame();
        load_frame(started);
        run_core($urandom_range(2, 12), W'($urandom), $urandom_range(1, 5), 1'b1);

        // Randomized frames
        for (int n = 0; n < 4; n++) begin
            randomize_frame();
            load_frame(started);
            run_core($urandom_range(1, 12), W'($urandom), $urandom_range(1, 5), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
